// File: rtl/axi4_lite_master_if.sv
// axi4_lite_master_if: AXI4-Lite bus bundle between a single master and a slave.
// Latency: none (wires only).
// Backpressure: carried by the per-channel VALID/READY pairs.
// Signals: AW (addr/valid/ready), W (data/strb/valid/ready), B (resp/valid/ready),
//          AR (addr/valid/ready), R (data/resp/valid/ready).
interface axi4_lite_master_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]      M_AWADDR;
  logic                    M_AWVALID;
  logic                    M_AWREADY;
  logic [DATA_WIDTH-1:0]   M_WDATA;
  logic [DATA_WIDTH/8-1:0] M_WSTRB;
  logic                    M_WVALID;
  logic                    M_WREADY;
  logic [1:0]              M_BRESP;
  logic                    M_BVALID;
  logic                    M_BREADY;
  logic [ADDRESS-1:0]      M_ARADDR;
  logic                    M_ARVALID;
  logic                    M_ARREADY;
  logic [DATA_WIDTH-1:0]   M_RDATA;
  logic [1:0]              M_RRESP;
  logic                    M_RVALID;
  logic                    M_RREADY;

  modport master (
    output M_AWADDR, M_AWVALID, input M_AWREADY,
    output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
    input  M_BRESP, M_BVALID, output M_BREADY,
    output M_ARADDR, M_ARVALID, input M_ARREADY,
    input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY
  );

  modport slave (
    input  M_AWADDR, M_AWVALID, output M_AWREADY,
    input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
    output M_BRESP, M_BVALID, input M_BREADY,
    input  M_ARADDR, M_ARVALID, output M_ARREADY,
    output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
  );
endinterface

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: one-outstanding AXI4-Lite master turning cmd requests into bus transactions.
// Latency: 3 cycles acceptance->rsp_valid with zero-wait slave; next cmd accepted in the rsp_valid cycle.
// Backpressure: cmd_ready low while a transaction is in flight; every VALID held with its payload until READY.
// Ports: ACLK, ARESETN (async, active-low); cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_wdata/cmd_wstrb request;
//        rsp_valid/rsp_rdata/rsp_resp one-cycle completion; m_axi = AXI4-Lite master modport.
// Option: define AXI_MASTER_TIMEOUT_EN to abort a stalled transaction after TIMEOUT_CYCLES with SLVERR.
module axi4_lite_master #(
  parameter int ADDRESS        = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [ADDRESS-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi4_lite_master_if.master      m_axi
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi4_lite_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic                    aw_pend, w_pend;
  logic [ADDRESS-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    cmd_acc;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                    timeout;

  // Gating with ARESETN keeps cmd_ready low during reset even though state already reads IDLE.
  assign cmd_ready = ARESETN && (state == IDLE);
  assign cmd_acc   = cmd_valid && cmd_ready;

  // AW and W are tracked by independent pending flags so either may complete first.
  assign aw_hs = aw_pend && m_axi.M_AWREADY;
  assign w_hs  = w_pend && m_axi.M_WREADY;
  assign b_hs  = (state == WRESP) && m_axi.M_BVALID;
  assign ar_hs = (state == RADDR) && m_axi.M_ARREADY;
  assign r_hs  = (state == RDATA) && m_axi.M_RVALID;

  assign m_axi.M_AWVALID = aw_pend;
  assign m_axi.M_AWADDR  = addr_q;
  assign m_axi.M_WVALID  = w_pend;
  assign m_axi.M_WDATA   = wdata_q;
  assign m_axi.M_WSTRB   = wstrb_q;
  assign m_axi.M_BREADY  = (state == WRESP);
  assign m_axi.M_ARVALID = (state == RADDR);
  assign m_axi.M_ARADDR  = addr_q;
  assign m_axi.M_RREADY  = (state == RDATA);

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic           hs_any;
  logic [TCW-1:0] to_cnt;

  assign hs_any = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  // Counts consecutive busy cycles without any handshake; a handshake restarts the window.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      to_cnt <= '0;
    end else if ((state == IDLE) || hs_any) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th stalled cycle; a handshake in that same cycle wins.
  assign timeout = (state != IDLE) && !hs_any && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (cmd_acc) state_nxt = cmd_rw ? WRITE : RADDR;
      // Leave once each channel has either already completed or completes this cycle.
      WRITE: if ((!aw_pend || m_axi.M_AWREADY) && (!w_pend || m_axi.M_WREADY)) state_nxt = WRESP;
      WRESP: if (m_axi.M_BVALID) state_nxt = IDLE;
      RADDR: if (m_axi.M_ARREADY) state_nxt = RDATA;
      RDATA: if (m_axi.M_RVALID) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  // Command capture and write-channel pending flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (timeout) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (cmd_acc) begin
      aw_pend <= cmd_rw;
      w_pend  <= cmd_rw;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end else begin
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
    end
  end

  // Completion: rsp_valid is a single-cycle pulse following the B/R handshake or a timeout.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      if (b_hs) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= m_axi.M_BRESP;
      end else if (r_hs) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= m_axi.M_RDATA;
        rsp_resp  <= m_axi.M_RRESP;
      end else if (timeout) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed bench for axi4_lite_master with a delay-programmable slave.
// Latency: n/a.
// Backpressure: slave READY/VALID delays are set per vector.
module tb_axi4_lite_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_rw = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          cmd_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  int n_chk = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_master_if #(.ADDRESS(AW), .DATA_WIDTH(DW)) axi ();

  axi4_lite_master #(.ADDRESS(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi(axi)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- slave with programmable delays ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic [1:0]    s_bresp = 2'b00, s_rresp = 2'b00;
  logic [DW-1:0] s_rdata = '0;
  logic aw_ok, w_ok, b_pend, r_pend, aw_now, w_now;

  assign axi.M_AWREADY = (aw_cnt >= aw_dly);
  assign axi.M_WREADY  = (w_cnt >= w_dly);
  assign axi.M_ARREADY = (ar_cnt >= ar_dly);
  assign axi.M_BVALID  = b_pend && (b_cnt >= b_dly);
  assign axi.M_RVALID  = r_pend && (r_cnt >= r_dly);
  assign axi.M_BRESP   = s_bresp;
  assign axi.M_RRESP   = s_rresp;
  assign axi.M_RDATA   = s_rdata;
  assign aw_now = aw_ok || (axi.M_AWVALID && axi.M_AWREADY);
  assign w_now  = w_ok || (axi.M_WVALID && axi.M_WREADY);

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_ok <= 1'b0; w_ok <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_cnt <= (axi.M_AWVALID && !axi.M_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.M_WVALID && !axi.M_WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (axi.M_ARVALID && !axi.M_ARREADY) ? ar_cnt + 1 : 0;
      if (aw_now && w_now && !b_pend) begin
        b_pend <= 1'b1; aw_ok <= 1'b0; w_ok <= 1'b0;
      end else begin
        aw_ok <= aw_now; w_ok <= w_now;
      end
      if (b_pend) begin
        if (axi.M_BVALID && axi.M_BREADY) begin b_pend <= 1'b0; b_cnt <= 0; end
        else b_cnt <= b_cnt + 1;
      end
      if (axi.M_ARVALID && axi.M_ARREADY) r_pend <= 1'b1;
      if (r_pend) begin
        if (axi.M_RVALID && axi.M_RREADY) begin r_pend <= 1'b0; r_cnt <= 0; end
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  // One command in flight; each channel is "owed" until its handshake; the response
  // is due the cycle after the B/R handshake (or after TO stalled cycles when enabled).
  bit            m_busy, m_wr, m_aw, m_w, m_ar, m_due;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_rs;
  bit            e_rdy, e_aw, e_w, e_br, e_ar, e_rr, acc, done, hs;
  int            stall;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      m_busy = 0; m_due = 0; stall = 0;
    end else begin
      e_rdy = !m_busy;
      e_aw  = m_busy && m_wr && !m_aw;
      e_w   = m_busy && m_wr && !m_w;
      e_br  = m_busy && m_wr && m_aw && m_w;
      e_ar  = m_busy && !m_wr && !m_ar;
      e_rr  = m_busy && !m_wr && m_ar;

      chk("cmd_ready", cmd_ready, e_rdy);
      chk("rsp_valid", rsp_valid, m_due);
      if (m_due) begin
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("rsp_resp", rsp_resp, m_rs);
      end
      chk("awvalid", axi.M_AWVALID, e_aw);
      if (e_aw) chk("awaddr", axi.M_AWADDR, m_addr);
      chk("wvalid", axi.M_WVALID, e_w);
      if (e_w) begin
        chk("wdata", axi.M_WDATA, m_wdata);
        chk("wstrb", axi.M_WSTRB, m_wstrb);
      end
      chk("bready", axi.M_BREADY, e_br);
      chk("arvalid", axi.M_ARVALID, e_ar);
      if (e_ar) chk("araddr", axi.M_ARADDR, m_addr);
      chk("rready", axi.M_RREADY, e_rr);

      m_due = 0; hs = 0; done = 0;
      acc = e_rdy && cmd_valid;
      if (e_aw && axi.M_AWREADY) begin m_aw = 1; hs = 1; end
      if (e_w && axi.M_WREADY)   begin m_w = 1; hs = 1; end
      if (e_ar && axi.M_ARREADY) begin m_ar = 1; hs = 1; end
      if (e_br && axi.M_BVALID) begin done = 1; m_rd = '0; m_rs = axi.M_BRESP; end
      if (e_rr && axi.M_RVALID) begin done = 1; m_rd = axi.M_RDATA; m_rs = axi.M_RRESP; end
      if (done) begin
        m_busy = 0; m_due = 1; stall = 0;
      end else if (m_busy) begin
        stall = hs ? 0 : stall + 1;
`ifdef AXI_MASTER_TIMEOUT_EN
        if (stall == TO) begin
          m_busy = 0; m_due = 1; m_rd = '0; m_rs = 2'b10; stall = 0;
        end
`endif
      end
      if (acc) begin
        m_busy = 1; m_wr = cmd_rw; m_addr = cmd_addr; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
        m_aw = 0; m_w = 0; m_ar = 0; stall = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_cmd(input string nm, input bit rw, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int awd, input int wdd, input int bd, input int ard, input int rd,
                        input logic [1:0] br, input logic [31:0] rdat, input logic [1:0] rr,
                        input logic [31:0] e_rd, input logic [1:0] e_rs, input int e_lat);
    int n;
    aw_dly = awd; w_dly = wdd; b_dly = bd; ar_dly = ard; r_dly = rd;
    s_bresp = br; s_rdata = rdat; s_rresp = rr;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!cmd_ready && n < 50);
    chk({nm, "_accept"}, cmd_ready, 1'b1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!rsp_valid && n < 2000);
    chk({nm, "_latency"}, n, e_lat);
    chk({nm, "_rdata"}, rsp_rdata, e_rd);
    chk({nm, "_resp"}, rsp_resp, e_rs);
    @(negedge ACLK);
    chk({nm, "_pulse_len"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int n;
    // reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_valids", {axi.M_AWVALID, axi.M_WVALID, axi.M_BREADY, axi.M_ARVALID, axi.M_RREADY}, 5'b0);
    @(posedge ACLK); #2; ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst_release_ready", cmd_ready, 1'b1);

    do_cmd("wr_basic", 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0,
           2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 3);
    do_cmd("wr_aw_late", 1, 32'h34, 32'hCAFEF00D, 4'hC, 4, 0, 0, 0, 0,
           2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 7);
    do_cmd("wr_w_late_decerr", 1, 32'h1002, 32'h00A1B2C3, 4'h3, 0, 2, 2, 0, 0,
           2'b11, 32'h0, 2'b00, 32'h0, 2'b11, 7);
    do_cmd("rd_slverr", 0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0,
           2'b00, 32'h12345678, 2'b10, 32'h12345678, 2'b10, 3);
    do_cmd("rd_slow_unaligned", 0, 32'h1003, 32'h0, 4'h0, 0, 0, 0, 2, 1,
           2'b00, 32'h0BADF00D, 2'b00, 32'h0BADF00D, 2'b00, 6);

    // back-to-back reads; the second command is presented while busy and must not disturb the first
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    s_rdata = 32'hA5A50001; s_rresp = 2'b00;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h40;
    @(negedge ACLK);
    chk("b2b_accept1", cmd_ready, 1'b1);
    @(posedge ACLK); #1;
    cmd_addr = 32'h44;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!rsp_valid && n < 50);
    chk("b2b_latency1", n, 3);
    chk("b2b_rdata1", rsp_rdata, 32'hA5A50001);
    chk("b2b_ready_at_rsp", cmd_ready, 1'b1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0; s_rdata = 32'hA5A50002;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!rsp_valid && n < 50);
    chk("b2b_latency2", n, 3);
    chk("b2b_rdata2", rsp_rdata, 32'hA5A50002);

    // reset while waiting in the read-data phase
    ar_dly = 0; r_dly = 20; s_rdata = 32'h55AA55AA;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h60;
    @(negedge ACLK);
    chk("rstmid_accept", cmd_ready, 1'b1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rstmid_in_rdata", axi.M_RREADY, 1'b1);
    @(posedge ACLK); #2; ARESETN = 1'b0; #1;
    chk("rstmid_cmd_ready", cmd_ready, 1'b0);
    chk("rstmid_rsp", {rsp_valid, rsp_resp}, 3'b0);
    chk("rstmid_rdata", rsp_rdata, 32'h0);
    chk("rstmid_valids", {axi.M_AWVALID, axi.M_WVALID, axi.M_BREADY, axi.M_ARVALID, axi.M_RREADY}, 5'b0);
    chk("rstmid_addrs", {axi.M_AWADDR, axi.M_ARADDR}, 64'h0);
    chk("rstmid_wpayload", {axi.M_WSTRB, axi.M_WDATA}, 36'h0);
    repeat (2) @(posedge ACLK); #2; ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rstmid_release_ready", cmd_ready, 1'b1);
    chk("rstmid_no_rsp", rsp_valid, 1'b0);

    do_cmd("wr_after_rst", 1, 32'h10, 32'h01020304, 4'h5, 0, 0, 0, 0, 0,
           2'b00, 32'h0, 2'b00, 32'h0, 2'b00, 3);

`ifdef AXI_MASTER_TIMEOUT_EN
    do_cmd("rd_timeout", 0, 32'h50, 32'h0, 4'h0, 0, 0, 0, 100000, 0,
           2'b00, 32'hFFFFFFFF, 2'b00, 32'h0, 2'b10, TO + 1);
    do_cmd("rd_after_timeout", 0, 32'h54, 32'h0, 4'h0, 0, 0, 0, 0, 0,
           2'b00, 32'h13572468, 2'b00, 32'h13572468, 2'b00, 3);
`endif

    repeat (3) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL provide parameter ADDRESS, default 32, AXI address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, AXI data width; WSTRB width is DATA_WIDTH/8.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 256, response timeout in cycles; used only when AXI_MASTER_TIMEOUT_EN is defined.
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1  user command request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_rw  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDRESS  transaction address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-014 rsp_resp  out  2  BRESP/RRESP of the completed transaction.
REQ-015 M_AWADDR/M_AWVALID out ADDRESS/1, M_AWREADY in 1: write address channel.
REQ-016 M_WDATA/M_WSTRB/M_WVALID out DATA_WIDTH/DATA_WIDTH/8/1, M_WREADY in 1: write data channel.
REQ-017 M_BRESP in 2, M_BVALID in 1, M_BREADY out 1: write response channel.
REQ-018 M_ARADDR/M_ARVALID out ADDRESS/1, M_ARREADY in 1: read address channel.
REQ-019 M_RDATA in DATA_WIDTH, M_RRESP in 2, M_RVALID in 1, M_RREADY out 1: read data channel.

Function
REQ-020 The FSM SHALL have the states IDLE, WRITE, WRESP, RADDR and RDATA.
REQ-021 cmd_ready SHALL equal (state==IDLE); a command is accepted on cmd_valid&&cmd_ready, and addr, wdata, wstrb and rw are registered at acceptance.
REQ-022 Acceptance SHALL move IDLE->WRITE if cmd_rw=1, otherwise IDLE->RADDR.
REQ-023 In WRITE, M_AWVALID and M_WVALID SHALL both assert on the first cycle, and each SHALL deassert independently on the cycle after its own handshake; either order or the same cycle is legal.
REQ-024 WRITE->WRESP SHALL occur on the edge at which both the AW and W handshakes have completed.
REQ-025 M_BREADY SHALL be 1 only in WRESP; on M_BVALID, rsp_resp<=M_BRESP, rsp_rdata<=0, rsp_valid pulses next cycle, and the FSM goes to IDLE.
REQ-026 M_ARVALID SHALL be 1 only in RADDR; on M_ARREADY the FSM goes to RDATA.
REQ-027 M_RREADY SHALL be 1 only in RDATA; on M_RVALID, rsp_rdata<=M_RDATA, rsp_resp<=M_RRESP, rsp_valid pulses next cycle, and the FSM goes to IDLE.
REQ-028 Once asserted, every VALID and its payload SHALL be held stable until its handshake.
REQ-029 Addresses SHALL pass unchanged: no alignment and no increment. SLVERR/DECERR SHALL be reported, not retried.
REQ-030 Minimum latency from acceptance to rsp_valid SHALL be 3 cycles for both reads and writes; with zero-wait slaves, back-to-back commands SHALL be accepted on the same cycle as rsp_valid.
REQ-031 cmd_valid while not in IDLE SHALL be ignored; there is no queuing.

Reset
REQ-032 ARESETN low SHALL asynchronously force state=IDLE and all VALID/READY outputs, rsp_valid, rsp_rdata, rsp_resp and all M_* payloads to 0; cmd_ready SHALL be 0 while ARESETN is low.
REQ-033 Reset mid-transaction SHALL abandon it with no rsp_valid; after release the block SHALL be in IDLE with cmd_ready=1 on the first cycle.

Configuration
REQ-034 With AXI_MASTER_TIMEOUT_EN defined, a counter SHALL count cycles spent in WRITE/WRESP/RADDR/RDATA without a completing handshake; reaching TIMEOUT_CYCLES SHALL drop all VALIDs, pulse rsp_valid with rsp_resp=2'b10 and rsp_rdata=0, and return to IDLE; the counter SHALL clear on every handshake.
REQ-035 Without AXI_MASTER_TIMEOUT_EN, no counter SHALL exist and the block SHALL wait indefinitely.

Verification
REQ-036 Write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, all READYs tied 1, BRESP=0 -> AW/W seen cycle 1, rsp_valid at cycle 3, rsp_resp=0.
REQ-037 Write with AWREADY delayed 4 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID is held with a stable address, and WRESP is entered only after AW completes.
REQ-038 Read addr=0x20, RDATA=0x12345678, RRESP=2'b10 -> rsp_rdata=0x12345678, rsp_resp=2'b10, single-cycle rsp_valid.
REQ-039 ARESETN pulsed low while in RDATA -> all outputs 0 immediately, no rsp_valid, cmd_ready=1 the first cycle after release.
REQ-040 (AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8) read with ARREADY held 0 -> ARVALID drops after 8 cycles, rsp_resp=2'b10, FSM returns to IDLE.
